tdm_demux4: RTL and testbench

Time-division 1:4 demultiplexer: the receive-side counterpart of the 4:1 channel multiplexer. It takes a serialised sample stream carrying channels a, b, c, d in rotating slots, aligns to a frame-sync marker, and presents each complete frame on four parallel registered outputs. Sample slot order matches the multiplexer select encoding: {s0,s1} = 00→a, 01→b, 10→c, 11→d.

---
 rtl/tdm_demux4_pkg.sv | 10 +
 rtl/tdm_demux4_if.sv | 23 ++
 rtl/tdm_demux4_slot_ctr.sv | 20 ++
 rtl/tdm_demux4.sv | 82 ++++++++
 tb/tb_tdm_demux4.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/tdm_demux4_pkg.sv
// tdm_demux_pkg: shared types and constants for the 1:4 TDM demultiplexer
package tdm_demux_pkg;
  localparam int SLOT_W = 2;
  localparam int DEF_WIDTH = 8;
  localparam logic [SLOT_W-1:0] SLOT_A = 2'b00;
  localparam logic [SLOT_W-1:0] SLOT_B = 2'b01;
  localparam logic [SLOT_W-1:0] SLOT_C = 2'b10;
  localparam logic [SLOT_W-1:0] SLOT_D = 2'b11;
  typedef enum logic {HUNT, LOCKED} state_e;
endpackage

// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: serial sample input and parallel frame output bundle
interface tdm_demux4_if #(parameter int WIDTH = tdm_demux_pkg::DEF_WIDTH);
  logic [WIDTH-1:0] din;
  logic din_valid;
  logic sync;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic s0;
  logic s1;
  logic frame_valid;
  logic locked;
  logic sync_err;
  modport master (
    output din, din_valid, sync,
    input a, b, c, d, s0, s1, frame_valid, locked, sync_err
  );
  modport slave (
    input din, din_valid, sync,
    output a, b, c, d, s0, s1, frame_valid, locked, sync_err
  );
endinterface

// File: rtl/tdm_demux4_slot_ctr.sv
// tdm_slot_ctr: 2-bit wrapping slot counter with clear, re-align load and enable
module tdm_slot_ctr
  import tdm_demux_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_load,
  input  logic              i_clr,
  output logic [SLOT_W-1:0] o_slot
);
  logic [SLOT_W-1:0] r_slot;
  // a sync sample always occupies slot a, so re-align lands on slot b
  always_ff @(posedge clk or posedge rst)
    if (rst) r_slot <= SLOT_A;
    else if (i_clr) r_slot <= SLOT_A;
    else if (i_load) r_slot <= SLOT_B;
    else if (i_en) r_slot <= r_slot + 1'b1;
  assign o_slot = r_slot;
endmodule

// File: rtl/tdm_demux4.sv
// tdm_demux4: aligns a 4-slot TDM stream on sync and presents whole frames on a..d
module tdm_demux4
  import tdm_demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic        clk,
  input logic        rst,
  tdm_demux4_if.slave bus
);
  state_e r_state, w_next;
  logic [SLOT_W-1:0] w_slot;
  logic w_load, w_en, w_clr, w_err, w_done;
  logic [WIDTH-1:0] r_sa, r_sb, r_sc, r_a, r_b, r_c, r_d;
  logic r_fv, r_err;
  tdm_slot_ctr u_ctr (
    .clk    (clk),
    .rst    (rst),
    .i_en   (w_en),
    .i_load (w_load),
    .i_clr  (w_clr),
    .o_slot (w_slot)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= HUNT;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_en = 1'b0;
    w_clr = 1'b0;
    w_err = 1'b0;
    w_done = 1'b0;
    if (bus.din_valid) begin
      if (bus.sync) begin
        w_load = 1'b1;
        w_next = LOCKED;
        w_err = (r_state == LOCKED) && (w_slot != SLOT_A);
      end else if (r_state == LOCKED) begin
        w_err = (w_slot == SLOT_A);
        w_clr = w_err;
        w_next = w_err ? HUNT : LOCKED;
        w_en = !w_err;
        w_done = (w_slot == SLOT_D);
      end
    end
  end
  // slot d has no staging register: it goes straight to d with the rest
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sa <= '0;
      r_sb <= '0;
      r_sc <= '0;
      r_a <= '0;
      r_b <= '0;
      r_c <= '0;
      r_d <= '0;
      r_fv <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (w_load) r_sa <= bus.din;
      if (w_en && w_slot == SLOT_B) r_sb <= bus.din;
      if (w_en && w_slot == SLOT_C) r_sc <= bus.din;
      if (w_done) begin
        r_a <= r_sa;
        r_b <= r_sb;
        r_c <= r_sc;
        r_d <= bus.din;
      end
      r_fv <= w_done;
      r_err <= w_err;
    end
  assign bus.a = r_a;
  assign bus.b = r_b;
  assign bus.c = r_c;
  assign bus.d = r_d;
  assign bus.s0 = w_slot[1];
  assign bus.s1 = w_slot[0];
  assign bus.frame_valid = r_fv;
  assign bus.locked = (r_state == LOCKED);
  assign bus.sync_err = r_err;
endmodule

// File: tb/tb_tdm_demux4.sv
// tb_tdm_demux4: scenario and randomized checks against a queue-based frame model
module tb_tdm_demux4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  tdm_demux4_if #(.WIDTH(8)) bus ();
  tdm_demux4 #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] q[$];
  logic m_locked, m_fv, m_err;
  logic [7:0] m_a, m_b, m_c, m_d;
  function automatic logic [1:0] m_slot();
    int n;
    logic [1:0] s;
    n = m_locked ? q.size() : 0;
    s = n[1:0];
    return s;
  endfunction
  function automatic logic [36:0] exp_vec();
    logic [1:0] s;
    s = m_slot();
    return {m_a, m_b, m_c, m_d, s[1], s[0], m_fv, m_locked, m_err};
  endfunction
  function automatic logic [36:0] dut_vec();
    return {bus.a, bus.b, bus.c, bus.d, bus.s0, bus.s1, bus.frame_valid, bus.locked, bus.sync_err};
  endfunction
  task automatic model_reset();
    q.delete();
    m_locked = 0; m_fv = 0; m_err = 0;
    m_a = 0; m_b = 0; m_c = 0; m_d = 0;
  endtask
  task automatic model_sample(input logic s, input logic [7:0] dn);
    if (!m_locked) begin
      if (s) begin q.delete(); q.push_back(dn); m_locked = 1; end
    end else if (s) begin
      m_err = (q.size() != 0);
      q.delete();
      q.push_back(dn);
    end else if (q.size() == 0) begin
      m_err = 1;
      m_locked = 0;
    end else begin
      q.push_back(dn);
      if (q.size() == 4) begin
        m_a = q[0]; m_b = q[1]; m_c = q[2]; m_d = q[3];
        m_fv = 1;
        q.delete();
      end
    end
  endtask
  task automatic step(input logic v, input logic s, input logic [7:0] dn);
    bus.din_valid = v;
    bus.sync = s;
    bus.din = dn;
    @(posedge clk);
    m_fv = 0;
    m_err = 0;
    if (v) model_sample(s, dn);
    #1;
  endtask
  task automatic test_reset();
    bus.din_valid = 0; bus.sync = 0; bus.din = 0;
    rst = 1;
    model_reset();
    @(posedge clk);
    #1;
    n_tests++;
    if (dut_vec() !== 37'd0) begin n_fail++; $display("FAIL reset_outputs got %h want 0", dut_vec()); end
    #2 rst = 0;
  endtask
  task automatic test_clean();
    step(1, 1, 8'h11);
    n_tests++;
    if (bus.locked !== 1'b1 || bus.frame_valid !== 1'b0 || {bus.s0, bus.s1} !== 2'b01) begin
      n_fail++; $display("FAIL clean_first got lk=%b fv=%b s=%b%b want 1 0 01", bus.locked, bus.frame_valid, bus.s0, bus.s1);
    end
    step(1, 0, 8'h22);
    step(1, 0, 8'h33);
    step(1, 0, 8'h44);
    n_tests++;
    if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid} !== {32'h11223344, 1'b1}) begin
      n_fail++; $display("FAIL clean_frame got %h%h%h%h fv=%b want 11223344 fv=1", bus.a, bus.b, bus.c, bus.d, bus.frame_valid);
    end
    step(0, 0, 8'h00);
    n_tests++;
    if (bus.frame_valid !== 1'b0 || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL clean_fv_drop got %h want %h", dut_vec(), exp_vec());
    end
  endtask
  task automatic test_gapped();
    logic [7:0] smp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [1:0] held;
    int bad = 0;
    for (int i = 0; i < 4; i++) begin
      step(1, i == 0, smp[i]);
      held = {bus.s0, bus.s1};
      for (int g = 0; g < 3; g++) begin
        step(0, 1, 8'hEE);
        if ({bus.s0, bus.s1} !== held || bus.sync_err !== 1'b0 || bus.frame_valid !== 1'b0) bad++;
      end
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL gapped_hold got %0d bad gap cycles want 0", bad); end
    n_tests++;
    if ({bus.a, bus.b, bus.c, bus.d} !== 32'h11223344 || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL gapped_frame got %h want %h", dut_vec(), exp_vec());
    end
  endtask
  task automatic test_early_sync();
    step(1, 1, 8'hA0);
    step(1, 0, 8'hA1);
    step(1, 1, 8'hB0);
    n_tests++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b1 || bus.frame_valid !== 1'b0) begin
      n_fail++; $display("FAIL early_err got err=%b lk=%b fv=%b want 1 1 0", bus.sync_err, bus.locked, bus.frame_valid);
    end
    step(1, 0, 8'hB1);
    n_tests++;
    if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL early_err_pulse got %b want 0", bus.sync_err); end
    step(1, 0, 8'hB2);
    step(1, 0, 8'hB3);
    n_tests++;
    if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid, bus.locked} !== {32'hB0B1B2B3, 2'b11}) begin
      n_fail++; $display("FAIL early_frame got %h want B0B1B2B3 fv=1 lk=1", dut_vec());
    end
  endtask
  task automatic test_missing_sync();
    step(1, 0, 8'h55);
    n_tests++;
    if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || {bus.a, bus.b, bus.c, bus.d} !== 32'hB0B1B2B3) begin
      n_fail++; $display("FAIL missing_err got %h want abcd=B0B1B2B3 err=1 lk=0", dut_vec());
    end
    step(1, 0, 8'h56);
    step(1, 0, 8'h57);
    n_tests++;
    if (bus.locked !== 1'b0 || bus.sync_err !== 1'b0 || {bus.s0, bus.s1} !== 2'b00 || dut_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL missing_hunt got %h want %h", dut_vec(), exp_vec());
    end
  endtask
  task automatic test_async_reset();
    step(1, 1, 8'h61);
    step(1, 0, 8'h62);
    #2 rst = 1;
    #1;
    model_reset();
    n_tests++;
    if (dut_vec() !== 37'd0) begin n_fail++; $display("FAIL async_reset got %h want 0", dut_vec()); end
    #2 rst = 0;
    step(1, 0, 8'h63);
    n_tests++;
    if (bus.locked !== 1'b0 || bus.sync_err !== 1'b0) begin
      n_fail++; $display("FAIL async_hunt got lk=%b err=%b want 0 0", bus.locked, bus.sync_err);
    end
    step(1, 1, 8'h71);
    step(1, 0, 8'h72);
    step(1, 0, 8'h73);
    step(1, 0, 8'h74);
    n_tests++;
    if ({bus.a, bus.b, bus.c, bus.d, bus.frame_valid} !== {32'h71727374, 1'b1}) begin
      n_fail++; $display("FAIL async_frame got %h want 71727374 fv=1", dut_vec());
    end
  endtask
  task automatic test_random();
    int bad = 0;
    int frames = 0;
    logic v, s, nat;
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(3) != 0);
      nat = (m_slot() == 2'b00);
      s = ($urandom_range(9) == 0) ? !nat : nat;
      step(v, s, 8'($urandom));
      if (m_fv) frames++;
      if (dut_vec() !== exp_vec()) begin
        bad++;
        if (bad < 5) $display("FAIL random_cycle%0d got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL random_total got %0d bad cycles want 0", bad); end
    n_tests++;
    if (frames == 0) begin n_fail++; $display("FAIL random_frames got %0d completed frames want >0", frames); end
  endtask
  initial begin
    test_reset();
    test_clean();
    test_gapped();
    test_early_sync();
    test_missing_sync();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
